alu_ctrl_mdu: RTL

Parametrised successor to the CPU's combinational ALU controller. It keeps the ALUOp/funct decode for single-cycle ALU operations and adds an iterative multiply/divide unit (MDU) with HI/LO registers. For multi-cycle operations it drives a stall handshake to the pipeline. It sits in EX, between the main decoder and the ALU/result mux.

---
 rtl/alu_ctrl_pkg.sv | 51 +++++
 rtl/alu_ctrl_mdu_iter.sv | 67 ++++++
 rtl/alu_ctrl_mdu.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the EX-stage ALU controller and its
// iterative multiply/divide unit.
package alu_ctrl_pkg;

    // R-type funct field values
    localparam logic [5:0] FUNCT_MFHI  = 6'd16;
    localparam logic [5:0] FUNCT_MFLO  = 6'd18;
    localparam logic [5:0] FUNCT_MULT  = 6'd24;
    localparam logic [5:0] FUNCT_MULTU = 6'd25;
    localparam logic [5:0] FUNCT_DIV   = 6'd26;
    localparam logic [5:0] FUNCT_DIVU  = 6'd27;
    localparam logic [5:0] FUNCT_ADD   = 6'd32;
    localparam logic [5:0] FUNCT_SUB   = 6'd34;
    localparam logic [5:0] FUNCT_AND   = 6'd36;
    localparam logic [5:0] FUNCT_OR    = 6'd37;
    localparam logic [5:0] FUNCT_SLT   = 6'd42;

    // ALUOp class codes from the main decoder; width is set by the user
    localparam int unsigned ALUOP_RTYPE = 0;
    localparam int unsigned ALUOP_ADD   = 1;
    localparam int unsigned ALUOP_SUB   = 2;
    localparam int unsigned ALUOP_ADDI  = 3;
    localparam int unsigned ALUOP_SLT   = 4;
    localparam int unsigned ALUOP_AND   = 5;

    // ALU operation select codes
    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;

    // EX result mux select codes
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_HI  = 2'b01;
    localparam logic [1:0] RES_LO  = 2'b10;

    // MDU sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

    // True for the four funct codes that launch a multi-cycle MDU operation
    function automatic logic is_mdu_funct(input logic [5:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
               (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
    endfunction

endpackage

// File: rtl/alu_ctrl_mdu_iter.sv
// Iteration datapath for the MDU: one shift-add multiply step or one
// restoring-divide step per enabled clock. Operates on magnitudes only;
// sign handling lives in the top level. The next_* outputs show the
// result of the step about to be taken so the final step can be
// committed to HI/LO on the same edge.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo
);

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mq_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] mq_d;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // Compute one multiply or divide step from the current registers
    always_comb begin
        sum     = {1'b0, acc_q} + (mq_q[0] ? {1'b0, b_q} : '0);
        shifted = {acc_q, mq_q[WIDTH-1]};
        trial   = shifted - {1'b0, b_q};
        acc_d   = acc_q;
        mq_d    = mq_q;
        if (is_div) begin
            if (!trial[WIDTH]) begin
                acc_d = trial[WIDTH-1:0];
            end else begin
                acc_d = shifted[WIDTH-1:0];
            end
            mq_d = {mq_q[WIDTH-2:0], ~trial[WIDTH]};
        end else begin
            acc_d = sum[WIDTH:1];
            mq_d  = {sum[0], mq_q[WIDTH-1:1]};
        end
        next_hi = acc_d;
        next_lo = mq_d;
    end

    // Load fresh operands on accept, otherwise advance one step when enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            mq_q  <= '0;
            b_q   <= '0;
        end else if (load) begin
            acc_q <= '0;
            mq_q  <= a_in;
            b_q   <= b_in;
        end else if (step) begin
            acc_q <= acc_d;
            mq_q  <= mq_d;
        end
    end

endmodule

// File: rtl/alu_ctrl_mdu.sv
// EX-stage ALU controller with an attached iterative multiply/divide
// unit. Single-cycle ops are decoded combinationally; MDU ops stall the
// pipeline for WIDTH+1 cycles and commit to HI/LO in the DONE cycle.
module alu_ctrl_mdu
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int ALUOP_W = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    input  logic [ALUOP_W-1:0] ALUOp_i,
    input  logic [5:0]         funct_i,
    input  logic [WIDTH-1:0]   src1_i,
    input  logic [WIDTH-1:0]   src2_i,
    output logic [3:0]         ALUCtrl_o,
    output logic [1:0]         res_sel_o,
    output logic               stall_o,
    output logic               done_o,
    output logic               div_zero_o,
    output logic [WIDTH-1:0]   hi_o,
    output logic [WIDTH-1:0]   lo_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    mdu_state_t       state_q;
    mdu_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             last_step;
    logic             op_signed;
    logic             op_div;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             is_div_q;
    logic             neg_q;
    logic             rem_neg_q;
    logic             dz_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] iter_hi;
    logic [WIDTH-1:0] iter_lo;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;
    logic [2*WIDTH-1:0] prod;

    assign accept    = (state_q == IDLE) && valid_i && (ALUOp_i == '0) && is_mdu_funct(funct_i);
    assign last_step = (state_q == BUSY) && (cnt_q == CNT_W'(1));

    // Translate ALUOp/funct into the ALU select and the EX result select
    always_comb begin
        ALUCtrl_o = CTRL_AND;
        res_sel_o = RES_ALU;
        case (ALUOp_i)
            ALUOP_W'(ALUOP_RTYPE): begin
                case (funct_i)
                    FUNCT_ADD:  ALUCtrl_o = CTRL_ADD;
                    FUNCT_SUB:  ALUCtrl_o = CTRL_SUB;
                    FUNCT_AND:  ALUCtrl_o = CTRL_AND;
                    FUNCT_OR:   ALUCtrl_o = CTRL_OR;
                    FUNCT_SLT:  ALUCtrl_o = CTRL_SLT;
                    FUNCT_MFHI: res_sel_o = RES_HI;
                    FUNCT_MFLO: res_sel_o = RES_LO;
                    default:    ALUCtrl_o = CTRL_AND;
                endcase
            end
            ALUOP_W'(ALUOP_ADD):  ALUCtrl_o = CTRL_ADD;
            ALUOP_W'(ALUOP_ADDI): ALUCtrl_o = CTRL_ADD;
            ALUOP_W'(ALUOP_SUB):  ALUCtrl_o = CTRL_SUB;
            ALUOP_W'(ALUOP_SLT):  ALUCtrl_o = CTRL_SLT;
            ALUOP_W'(ALUOP_AND):  ALUCtrl_o = CTRL_AND;
            default:              ALUCtrl_o = CTRL_AND;
        endcase
    end

    // Strip operand signs so the iteration datapath only sees magnitudes
    always_comb begin
        op_signed = (funct_i == FUNCT_MULT) || (funct_i == FUNCT_DIV);
        op_div    = (funct_i == FUNCT_DIV) || (funct_i == FUNCT_DIVU);
        a_neg     = op_signed && src1_i[WIDTH-1];
        b_neg     = op_signed && src2_i[WIDTH-1];
        a_mag     = a_neg ? -src1_i : src1_i;
        b_mag     = b_neg ? -src2_i : src2_i;
    end

    mdu_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk     (clk_i),
        .rst     (rst_i),
        .load    (accept),
        .step    (state_q == BUSY),
        .is_div  (is_div_q),
        .a_in    (a_mag),
        .b_in    (b_mag),
        .next_hi (iter_hi),
        .next_lo (iter_lo)
    );

    // Re-apply signs to the final magnitudes; divide by zero forces LO to all ones
    always_comb begin
        prod   = neg_q ? -{iter_hi, iter_lo} : {iter_hi, iter_lo};
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
        if (is_div_q) begin
            fix_hi = rem_neg_q ? -iter_hi : iter_hi;
            if (dz_q) begin
                fix_lo = '1;
            end else begin
                fix_lo = neg_q ? -iter_lo : iter_lo;
            end
        end
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; valid_i is deliberately ignored in DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (last_step) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs derived from the state
    always_comb begin
        stall_o    = accept || (state_q == BUSY);
        done_o     = (state_q == DONE);
        div_zero_o = (state_q == DONE) && dz_q;
    end

    // Capture op flags on accept, count steps, and commit HI/LO on the last step
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else if (accept) begin
            cnt_q     <= CNT_W'(WIDTH);
            is_div_q  <= op_div;
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            dz_q      <= op_div && (src2_i == '0);
        end else if (state_q == BUSY) begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (last_step) begin
                hi_q <= fix_hi;
                lo_q <= fix_lo;
            end
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule
